// File: rtl/vgpr_retire_arbiter.sv
// Round-robin arbiter sharing the scoreboard retire port between per-requester retire FIFOs.
// Optional build macro VGPR_RETIRE_MERGE_EN fuses two adjacent single-word retires into one broadcast.
module vgpr_retire_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DEPTH   = 2,
  parameter int ADDR_W  = 10,
  parameter int WFID_W  = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*WFID_W-1:0] req_wfid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*4-1:0]      req_mask,
  output logic                      retired_valid,
  output logic [WFID_W-1:0]         retired_wfid,
  output logic [ADDR_W-1:0]         retired_operand_addr,
  output logic [3:0]                retired_operand_mask,
  output logic [NUM_REQ-1:0]        retired_src,
  output logic                      busy
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [SEL_W:0]   NREQ     = (SEL_W + 1)'(NUM_REQ);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] w_nonempty;
  logic [NUM_REQ-1:0] w_grant;
  logic [WFID_W-1:0]  w_head_wfid [NUM_REQ];
  logic [ADDR_W-1:0]  w_head_addr [NUM_REQ];
  logic [3:0]         w_head_mask [NUM_REQ];
`ifdef VGPR_RETIRE_MERGE_EN
  logic [WFID_W-1:0]  w_sec_wfid [NUM_REQ];
  logic [ADDR_W-1:0]  w_sec_addr [NUM_REQ];
  logic [3:0]         w_sec_mask [NUM_REQ];
  logic [NUM_REQ-1:0] w_two;
`endif

  logic               w_found;
  logic               w_merge;
  logic [SEL_W-1:0]   w_gnt_idx;
  logic [SEL_W:0]     w_sum;
  logic [SEL_W-1:0]   w_cand;
  logic [WFID_W-1:0]  w_h_wfid;
  logic [ADDR_W-1:0]  w_h_addr;
  logic [3:0]         w_h_mask;

  logic [SEL_W-1:0]   r_rr_ptr;
  logic               r_valid;
  logic [WFID_W-1:0]  r_wfid;
  logic [ADDR_W-1:0]  r_addr;
  logic [3:0]         r_mask;
  logic [NUM_REQ-1:0] r_src;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_q
      logic [WFID_W-1:0] r_wfid_mem [DEPTH];
      logic [ADDR_W-1:0] r_addr_mem [DEPTH];
      logic [3:0]        r_mask_mem [DEPTH];
      logic [PTR_W-1:0]  r_rptr;
      logic [PTR_W-1:0]  r_wptr;
      logic [CNT_W-1:0]  r_count;
      logic              w_push;
      logic [1:0]        w_pop_cnt;

      // Zero-mask requests are handshaken but never stored.
      assign req_ready[gi]   = (r_count < FULL_CNT);
      assign w_push          = req_valid[gi] && req_ready[gi] && (req_mask[gi*4 +: 4] != 4'b0000);
      assign w_nonempty[gi]  = (r_count != '0);
      assign w_pop_cnt       = !w_grant[gi] ? 2'd0 : (w_merge ? 2'd2 : 2'd1);
      assign w_head_wfid[gi] = r_wfid_mem[r_rptr];
      assign w_head_addr[gi] = r_addr_mem[r_rptr];
      assign w_head_mask[gi] = r_mask_mem[r_rptr];

`ifdef VGPR_RETIRE_MERGE_EN
      logic [PTR_W-1:0] w_rptr_nxt;
      assign w_rptr_nxt     = r_rptr + PTR_W'(1);
      assign w_sec_wfid[gi] = r_wfid_mem[w_rptr_nxt];
      assign w_sec_addr[gi] = r_addr_mem[w_rptr_nxt];
      assign w_sec_mask[gi] = r_mask_mem[w_rptr_nxt];
      assign w_two[gi]      = (r_count >= CNT_W'(2));
`endif

      always_ff @(posedge clk) begin
        if (w_push) begin
          r_wfid_mem[r_wptr] <= req_wfid[gi*WFID_W +: WFID_W];
          r_addr_mem[r_wptr] <= req_addr[gi*ADDR_W +: ADDR_W];
          r_mask_mem[r_wptr] <= req_mask[gi*4 +: 4];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rptr  <= '0;
          r_wptr  <= '0;
          r_count <= '0;
        end else begin
          r_wptr  <= r_wptr + PTR_W'(w_push);
          r_rptr  <= r_rptr + PTR_W'(w_pop_cnt);
          r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop_cnt);
        end
      end
    end
  endgenerate

  // First non-empty queue at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (SEL_W + 1)'(k);
      if (w_sum >= NREQ) begin
        w_sum = w_sum - NREQ;
      end
      w_cand = w_sum[SEL_W-1:0];
      if (!w_found && w_nonempty[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_grant  = w_found ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign w_h_wfid = w_head_wfid[w_gnt_idx];
  assign w_h_addr = w_head_addr[w_gnt_idx];
  assign w_h_mask = w_head_mask[w_gnt_idx];

`ifdef VGPR_RETIRE_MERGE_EN
  // Merge only strictly consecutive words of the same wavefront; no wrap at the top address.
  assign w_merge = w_found && w_two[w_gnt_idx]
                && (w_h_mask == 4'b0001) && (w_sec_mask[w_gnt_idx] == 4'b0001)
                && (w_sec_wfid[w_gnt_idx] == w_h_wfid)
                && (w_h_addr != {ADDR_W{1'b1}})
                && (w_sec_addr[w_gnt_idx] == w_h_addr + ADDR_W'(1));
`else
  assign w_merge = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_valid  <= 1'b0;
      r_wfid   <= '0;
      r_addr   <= '0;
      r_mask   <= '0;
      r_src    <= '0;
    end else begin
      r_valid <= w_found;
      if (w_found) begin
        r_rr_ptr <= (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + SEL_W'(1);
        r_wfid   <= w_h_wfid;
        r_addr   <= w_h_addr;
        r_mask   <= w_merge ? 4'b0011 : w_h_mask;
        r_src    <= w_grant;
      end
    end
  end

  assign retired_valid        = r_valid;
  assign retired_wfid         = r_wfid;
  assign retired_operand_addr = r_addr;
  assign retired_operand_mask = r_mask;
  assign retired_src          = r_src;
  assign busy                 = (|w_nonempty) | r_valid;

endmodule

// File: tb/tb_vgpr_retire_arbiter.sv
// Self-checking bench for vgpr_retire_arbiter: directed vector table, hand sequences, and
// randomized traffic scored against a queue-based reference model.
module tb_vgpr_retire_arbiter;
  localparam int NR    = 3;
  localparam int DEPTH = 2;
  localparam int AW    = 10;
  localparam int WW    = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*WW-1:0] req_wfid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*4-1:0]  req_mask = '0;
  logic             retired_valid;
  logic [WW-1:0]    retired_wfid;
  logic [AW-1:0]    retired_operand_addr;
  logic [3:0]       retired_operand_mask;
  logic [NR-1:0]    retired_src;
  logic             busy;

  vgpr_retire_arbiter #(.NUM_REQ(NR), .DEPTH(DEPTH), .ADDR_W(AW), .WFID_W(WW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wfid(req_wfid), .req_addr(req_addr), .req_mask(req_mask),
    .retired_valid(retired_valid), .retired_wfid(retired_wfid),
    .retired_operand_addr(retired_operand_addr), .retired_operand_mask(retired_operand_mask),
    .retired_src(retired_src), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0] wfid;
    logic [AW-1:0] addr;
    logic [3:0]    mask;
  } ent_t;

  typedef struct packed {
    logic [2:0]  v;
    logic [17:0] wf;
    logic [29:0] ad;
    logic [11:0] mk;
    logic [2:0]  ready;
    logic        rv;
    logic [5:0]  wfid;
    logic [9:0]  addr;
    logic [3:0]  mask;
    logic [2:0]  src;
    logic        busy;
  } vec_t;

  ent_t          mq [NR][$];
  int            m_rr;
  logic          e_rv;
  logic [WW-1:0] e_wfid;
  logic [AW-1:0] e_addr;
  logic [3:0]    e_mask;
  logic [NR-1:0] e_src;
  logic          e_busy;
  logic [NR-1:0] pre_ready;
  logic [NR-1:0] dut_ready_pre;
  int            checks = 0;
  int            failures = 0;
  int            bcast_src2 = 0;
  vec_t          tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mq[i].delete();
    m_rr   = 0;
    e_rv   = 1'b0;
    e_wfid = '0;
    e_addr = '0;
    e_mask = '0;
    e_src  = '0;
    e_busy = 1'b0;
  endtask

  // One clock edge of the reference: pop from the round-robin winner, then accept pushes.
  task automatic model_edge(input logic [NR-1:0] v, input logic [NR*WW-1:0] wf,
                            input logic [NR*AW-1:0] ad, input logic [NR*4-1:0] mk);
    ent_t h;
    ent_t n;
    int   g;
    g = -1;
    for (int i = 0; i < NR; i++) pre_ready[i] = (mq[i].size() < DEPTH);
    for (int k = 0; k < NR; k++) begin
      int c = (m_rr + k) % NR;
      if (g < 0 && mq[c].size() > 0) g = c;
    end
    if (g >= 0) begin
      h      = mq[g].pop_front();
      e_rv   = 1'b1;
      e_wfid = h.wfid;
      e_addr = h.addr;
      e_mask = h.mask;
      e_src  = NR'(1) << g;
`ifdef VGPR_RETIRE_MERGE_EN
      if (mq[g].size() > 0) begin
        ent_t s;
        s = mq[g][0];
        if (h.mask == 4'd1 && s.mask == 4'd1 && s.wfid == h.wfid &&
            h.addr != {AW{1'b1}} && s.addr == h.addr + 1'b1) begin
          void'(mq[g].pop_front());
          e_mask = 4'b0011;
        end
      end
`endif
      m_rr = (g + 1) % NR;
    end else begin
      e_rv = 1'b0;
    end
    for (int i = 0; i < NR; i++) begin
      if (v[i] && pre_ready[i] && mk[i*4 +: 4] != 4'd0) begin
        n.wfid = wf[i*WW +: WW];
        n.addr = ad[i*AW +: AW];
        n.mask = mk[i*4 +: 4];
        mq[i].push_back(n);
      end
    end
    e_busy = e_rv;
    for (int i = 0; i < NR; i++) if (mq[i].size() > 0) e_busy = 1'b1;
  endtask

  task automatic step(input logic [NR-1:0] v, input logic [NR*WW-1:0] wf,
                      input logic [NR*AW-1:0] ad, input logic [NR*4-1:0] mk, input bit check);
    req_valid = v;
    req_wfid  = wf;
    req_addr  = ad;
    req_mask  = mk;
    model_edge(v, wf, ad, mk);
    dut_ready_pre = req_ready;
    if (check) chk("req_ready", 32'(req_ready), 32'(pre_ready));
    @(posedge clk);
    #1;
    if (retired_valid) begin
      $display("bcast t=%0t src=%b wfid=%0d addr=0x%03h mask=%b", $time, retired_src,
               retired_wfid, retired_operand_addr, retired_operand_mask);
      if (retired_src[2]) bcast_src2++;
    end
    if (check) begin
      chk("retired_valid", 32'(retired_valid), 32'(e_rv));
      chk("retired_wfid", 32'(retired_wfid), 32'(e_wfid));
      chk("retired_addr", 32'(retired_operand_addr), 32'(e_addr));
      chk("retired_mask", 32'(retired_operand_mask), 32'(e_mask));
      chk("retired_src", 32'(retired_src), 32'(e_src));
      chk("busy", 32'(busy), 32'(e_busy));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0, 1'b1);
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_wfid  = '0;
    req_addr  = '0;
    req_mask  = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0]    rv;
    logic [NR*WW-1:0] rwf;
    logic [NR*AW-1:0] rad;
    logic [NR*4-1:0]  rmk;
    logic [AW-1:0]    last_addr [NR];
    logic [AW-1:0]    a;
    int               r;

    //        v       wf                       ad                                  mk                  ready   rv  wfid  addr     mask  src     busy
    tbl[0]  = '{3'b000, 18'h0,                   30'h0,                              12'h0,              3'b111, 1'b0, 6'd0,  10'h000, 4'h0, 3'b000, 1'b0};
    tbl[1]  = '{3'b010, {6'd0, 6'd5, 6'd0},      {10'h000, 10'h020, 10'h000},        {4'h0, 4'h3, 4'h0}, 3'b111, 1'b0, 6'd0,  10'h000, 4'h0, 3'b000, 1'b1};
    tbl[2]  = '{3'b000, 18'h0,                   30'h0,                              12'h0,              3'b111, 1'b1, 6'd5,  10'h020, 4'h3, 3'b010, 1'b1};
    tbl[3]  = '{3'b000, 18'h0,                   30'h0,                              12'h0,              3'b111, 1'b0, 6'd5,  10'h020, 4'h3, 3'b010, 1'b0};
    tbl[4]  = '{3'b111, {6'd12, 6'd11, 6'd10},   {10'h120, 10'h110, 10'h100},        {4'h4, 4'h2, 4'h1}, 3'b111, 1'b0, 6'd0,  10'h000, 4'h0, 3'b000, 1'b1};
    tbl[5]  = '{3'b111, {6'd22, 6'd21, 6'd20},   {10'h220, 10'h210, 10'h200},        {4'h8, 4'hE, 4'hF}, 3'b111, 1'b1, 6'd10, 10'h100, 4'h1, 3'b001, 1'b1};
    tbl[6]  = '{3'b110, {6'd32, 6'd31, 6'd30},   {10'h320, 10'h310, 10'h300},        {4'h1, 4'h1, 4'h1}, 3'b001, 1'b1, 6'd11, 10'h110, 4'h2, 3'b010, 1'b1};
    tbl[7]  = '{3'b000, 18'h0,                   30'h0,                              12'h0,              3'b011, 1'b1, 6'd12, 10'h120, 4'h4, 3'b100, 1'b1};
    tbl[8]  = '{3'b000, 18'h0,                   30'h0,                              12'h0,              3'b111, 1'b1, 6'd20, 10'h200, 4'hF, 3'b001, 1'b1};
    tbl[9]  = '{3'b000, 18'h0,                   30'h0,                              12'h0,              3'b111, 1'b1, 6'd21, 10'h210, 4'hE, 3'b010, 1'b1};
    tbl[10] = '{3'b000, 18'h0,                   30'h0,                              12'h0,              3'b111, 1'b1, 6'd22, 10'h220, 4'h8, 3'b100, 1'b1};
    tbl[11] = '{3'b000, 18'h0,                   30'h0,                              12'h0,              3'b111, 1'b0, 6'd22, 10'h220, 4'h8, 3'b100, 1'b0};
    tbl[12] = '{3'b001, {6'd0, 6'd0, 6'd7},      {10'h000, 10'h000, 10'h3FF},        {4'h0, 4'h0, 4'h0}, 3'b111, 1'b0, 6'd22, 10'h220, 4'h8, 3'b100, 1'b0};
    tbl[13] = '{3'b000, 18'h0,                   30'h0,                              12'h0,              3'b111, 1'b0, 6'd22, 10'h220, 4'h8, 3'b100, 1'b0};

    do_reset();
    chk("reset_ready", 32'(req_ready), 32'(3'b111));
    chk("reset_busy", 32'(busy), 32'(1'b0));

    // Directed vector table; rows 4.. start from a fresh reset so rr_ptr is 0.
    for (int i = 0; i < 14; i++) begin
      if (i == 4) do_reset();
      step(tbl[i].v, tbl[i].wf, tbl[i].ad, tbl[i].mk, 1'b0);
      chk("tbl_ready", 32'(dut_ready_pre), 32'(tbl[i].ready));
      chk("tbl_valid", 32'(retired_valid), 32'(tbl[i].rv));
      chk("tbl_wfid", 32'(retired_wfid), 32'(tbl[i].wfid));
      chk("tbl_addr", 32'(retired_operand_addr), 32'(tbl[i].addr));
      chk("tbl_mask", 32'(retired_operand_mask), 32'(tbl[i].mask));
      chk("tbl_src", 32'(retired_src), 32'(tbl[i].src));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].busy));
    end

    // Queue 0 reaches full while also being popped: push must still be refused.
    do_reset();
    step(3'b011, {6'd0, 6'd2, 6'd1}, {10'h0, 10'h050, 10'h040}, {4'h0, 4'h2, 4'h2}, 1'b1);
    step(3'b011, {6'd0, 6'd4, 6'd3}, {10'h0, 10'h052, 10'h042}, {4'h0, 4'h2, 4'h2}, 1'b1);
    step(3'b001, {6'd0, 6'd0, 6'd5}, {10'h0, 10'h000, 10'h044}, {4'h0, 4'h0, 4'h2}, 1'b1);
    step(3'b001, {6'd0, 6'd0, 6'd6}, {10'h0, 10'h000, 10'h046}, {4'h0, 4'h0, 4'h2}, 1'b1);
    chk("full_ready0", 32'(dut_ready_pre[0]), 32'(1'b0));
    idle(6);
    chk("full_drained", 32'(busy), 32'(1'b0));

    // Asynchronous reset with entries queued.
    do_reset();
    step(3'b111, {6'd1, 6'd2, 6'd3}, {10'h011, 10'h022, 10'h033}, {4'h1, 4'h2, 4'h4}, 1'b1);
    step(3'b111, {6'd4, 6'd5, 6'd6}, {10'h044, 10'h055, 10'h066}, {4'h8, 4'h3, 4'h6}, 1'b1);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(retired_valid), 32'(1'b0));
    chk("arst_wfid", 32'(retired_wfid), 32'(0));
    chk("arst_addr", 32'(retired_operand_addr), 32'(0));
    chk("arst_mask", 32'(retired_operand_mask), 32'(0));
    chk("arst_src", 32'(retired_src), 32'(0));
    chk("arst_busy", 32'(busy), 32'(1'b0));
    chk("arst_ready", 32'(req_ready), 32'(3'b111));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(5);

`ifdef VGPR_RETIRE_MERGE_EN
    // Queue 0 stalls queue 2 for one cycle so two adjacent words build up.
    do_reset();
    bcast_src2 = 0;
    step(3'b101, {6'd3, 6'd0, 6'd1}, {10'h100, 10'h0, 10'h000}, {4'h1, 4'h0, 4'h2}, 1'b1);
    step(3'b100, {6'd3, 6'd0, 6'd0}, {10'h101, 10'h0, 10'h000}, {4'h1, 4'h0, 4'h0}, 1'b1);
    idle(4);
    chk("merge_count", 32'(bcast_src2), 32'(1));
    do_reset();
    bcast_src2 = 0;
    step(3'b101, {6'd3, 6'd0, 6'd1}, {10'h100, 10'h0, 10'h000}, {4'h1, 4'h0, 4'h2}, 1'b1);
    step(3'b100, {6'd3, 6'd0, 6'd0}, {10'h102, 10'h0, 10'h000}, {4'h1, 4'h0, 4'h0}, 1'b1);
    idle(4);
    chk("nomerge_count", 32'(bcast_src2), 32'(2));
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < NR; i++) last_addr[i] = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        rv[i] = ($urandom_range(0, 99) < 45);
        rwf[i*WW +: WW] = 6'($urandom_range(0, 2));
        if ($urandom_range(0, 1) == 1) a = last_addr[i] + 10'd1;
        else a = 10'($urandom);
        last_addr[i] = a;
        rad[i*AW +: AW] = a;
        r = $urandom_range(0, 9);
        if (r == 0) rmk[i*4 +: 4] = 4'h0;
        else if (r < 5) rmk[i*4 +: 4] = 4'h1;
        else rmk[i*4 +: 4] = 4'($urandom);
      end
      step(rv, rwf, rad, rmk, 1'b1);
    end
    idle(8);
    chk("random_drained", 32'(busy), 32'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
